// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: one action per press/release, 4-digit hex entry buffer
// with backspace, enter (commit) and clear keys; release detected by a low-time timer.
//
// state        | meaning
// IDLE         | waiting for key_pressed to start a new press
// ACCEPT       | one cycle: apply the captured key code to the buffer
// WAIT_RELEASE | ignore the key until key_pressed stays low RELEASE_CYCLES cycles
module keypad_entry_ctrl #(
  parameter int RELEASE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_pressed,
  output logic [15:0] disp_value,
  output logic [3:0]  digit_en,
  output logic [15:0] entry_value,
  output logic        entry_valid,
  output logic        key_event
);

  localparam int TW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_TC  = TW'(RELEASE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};

  localparam logic [3:0] CODE_BKSP  = 4'hD;
  localparam logic [3:0] CODE_ENTER = 4'hE;
  localparam logic [3:0] CODE_CLEAR = 4'hF;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACCEPT       = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    code_q;
  logic [2:0]    count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      code_q      <= '0;
      count       <= '0;
      disp_value  <= '0;
      entry_value <= '0;
      entry_valid <= 1'b0;
      key_event   <= 1'b0;
    end else begin
      key_event   <= 1'b0;
      entry_valid <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (key_pressed) begin
            code_q <= key_code;
            state  <= ACCEPT;
          end
        end
        ACCEPT: begin
          key_event <= 1'b1;
          timer     <= '0;
          state     <= WAIT_RELEASE;
          case (code_q)
            CODE_BKSP: begin
              if (count != 3'd0) begin
                disp_value <= {4'h0, disp_value[15:4]};
                count      <= count - 3'd1;
              end
            end
            CODE_ENTER: begin
              entry_value <= disp_value;
              entry_valid <= 1'b1;
              disp_value  <= '0;
              count       <= '0;
            end
            CODE_CLEAR: begin
              disp_value <= '0;
              count      <= '0;
            end
            default: begin
              // A fifth digit is dropped but still acknowledged with key_event.
              if (count < 3'd4) begin
                disp_value <= {disp_value[11:0], code_q};
                count      <= count + 3'd1;
              end
            end
          endcase
        end
        WAIT_RELEASE: begin
          if (key_pressed) begin
            timer <= '0;
          end else if (timer == TIMER_TC) begin
            timer <= '0;
            state <= IDLE;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    digit_en = 4'b0000;
    case (count)
      3'd1:    digit_en = 4'b0001;
      3'd2:    digit_en = 4'b0011;
      3'd3:    digit_en = 4'b0111;
      3'd4:    digit_en = 4'b1111;
      default: digit_en = 4'b0000;
    endcase
  end

endmodule
